// File: rtl/driver_motor_pwm.sv
// Soft-start / soft-stop PWM driver for the motor pin.
// Ramps an 8-bit duty on run requests and enforces a hold-off after stops.
module driver_motor_pwm #(
    parameter int PRESC           = 4,
    parameter int RAMP_PERIODS    = 264,
    parameter int STEP            = 1,
    parameter int HOLDOFF_PERIODS = 2640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       motor_on,
    input  logic       estop,
    output logic       pwm_out,
    output logic [7:0] duty,
    output logic       running,
    output logic       holdoff,
    output logic [2:0] state
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam int HW = (HOLDOFF_PERIODS > 1) ? $clog2(HOLDOFF_PERIODS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [RW:0]   RAMP_N     = (RW + 1)'(RAMP_PERIODS);
    localparam logic [HW:0]   HOLD_N     = (HW + 1)'(HOLDOFF_PERIODS);
    localparam logic [8:0]    STEP9      = 9'(STEP);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        RUN       = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [7:0]    duty_q, duty_d;
    logic [RW-1:0] ramp_q, ramp_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pwm_q, pwm_d;

    logic          presc_last;
    logic          period_end;
    logic [RW:0]   ramp_nxt;
    logic [HW:0]   hold_nxt;
    logic          ramp_last;
    logic          hold_last;
    logic [8:0]    duty_sum;
    logic [7:0]    duty_up;
    logic [7:0]    duty_dn;

    assign presc_last = (presc_q == PRESC_LAST);
    assign period_end = presc_last && (pwm_cnt_q == 8'd255);
    assign ramp_nxt   = {1'b0, ramp_q} + 1'b1;
    assign hold_nxt   = {1'b0, hold_q} + 1'b1;
    assign ramp_last  = (ramp_nxt == RAMP_N);
    assign hold_last  = (hold_nxt == HOLD_N);
    assign duty_sum   = {1'b0, duty_q} + STEP9;
    assign duty_up    = duty_sum[8] ? 8'd255 : duty_sum[7:0];
    assign duty_dn    = ({1'b0, duty_q} > STEP9) ? (duty_q - STEP9[7:0]) : 8'd0;

    // Free-running prescaler, PWM counter and registered PWM compare.
    always_comb begin
        presc_d   = presc_last ? '0 : presc_q + 1'b1;
        pwm_cnt_d = presc_last ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        pwm_d     = (duty_q == 8'd255) || (pwm_cnt_q < duty_q);
    end

    // Ramp FSM: updates on period boundaries only, estop overrides at once.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        ramp_d  = ramp_q;
        hold_d  = hold_q;
        if (estop) begin
            state_d = HOLDOFF;
            duty_d  = 8'd0;
            ramp_d  = '0;
            hold_d  = '0;
        end else if (period_end) begin
            unique case (state_q)
                IDLE: begin
                    duty_d = 8'd0;
                    ramp_d = '0;
                    if (motor_on) state_d = RAMP_UP;
                end
                RAMP_UP: begin
                    if (!motor_on) begin
                        state_d = RAMP_DOWN;
                        ramp_d  = '0;
                    end else if (ramp_last) begin
                        ramp_d = '0;
                        duty_d = duty_up;
                        if (duty_up == 8'd255) state_d = RUN;
                    end else begin
                        ramp_d = ramp_nxt[RW-1:0];
                    end
                end
                RUN: begin
                    if (!motor_on) begin
                        state_d = RAMP_DOWN;
                        ramp_d  = '0;
                    end
                end
                RAMP_DOWN: begin
                    if (motor_on) begin
                        state_d = RAMP_UP;
                        ramp_d  = '0;
                    end else if (ramp_last) begin
                        ramp_d = '0;
                        duty_d = duty_dn;
                        if (duty_dn == 8'd0) begin
                            state_d = HOLDOFF;
                            hold_d  = '0;
                        end
                    end else begin
                        ramp_d = ramp_nxt[RW-1:0];
                    end
                end
                HOLDOFF: begin
                    if (hold_last) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_nxt[HW-1:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = 8'd0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            pwm_cnt_q <= 8'd0;
            duty_q    <= 8'd0;
            ramp_q    <= '0;
            hold_q    <= '0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            ramp_q    <= ramp_d;
            hold_q    <= hold_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
    assign duty    = duty_q;
    assign state   = state_q;
    assign running = (state_q == RUN);
    assign holdoff = (state_q == HOLDOFF);

endmodule

// File: doc/driver_motor_pwm.md
# driver_motor_pwm

Receiving end of the `motor_on` command from the control FSM. It replaces the direct on/off drive of the motor pin with a soft-start/soft-stop PWM drive. An on/off request becomes an 8-bit duty ramp, followed by a mandatory hold-off after every stop. It sits between `fsm_controle.motor_on` and the physical `MOTOR_OUT` pin, clocked by `CLOCK_27`.

## Interface
- `PRESC`, default 4: clocks per PWM count; PWM period = `PRESC`×256 clocks, about 26.4 kHz at 27 MHz.
- `RAMP_PERIODS`, default 264: PWM periods between duty steps.
- `STEP`, default 1: duty increment or decrement per step, range 1–255.
- `HOLDOFF_PERIODS`, default 2640: PWM periods the driver must stay stopped after reaching duty 0.
- `clk`, input, 1: system clock. One clock domain only.
- `reset`, input, 1: asynchronous, active-high reset.
- `motor_on`, input, 1: run request from the FSM. Level-sensitive, synchronous to `clk`.
- `estop`, input, 1: emergency stop. Synchronous, level-sensitive, highest priority.
- `pwm_out`, output, 1: registered PWM drive to the motor pin.
- `duty`, output, 8: current duty value.
- `running`, output, 1: high while in RUN.
- `holdoff`, output, 1: high while in HOLDOFF.
- `state`, output, 3: debug state code. IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, HOLDOFF=4.

## Operation
- **Counters.**
  - Prescaler `presc` counts 0..`PRESC`−1.
  - `pwm_cnt` (8 bit) advances when `presc`=`PRESC`−1 and wraps 255→0.
  - `period_end` = (`presc`=`PRESC`−1) and (`pwm_cnt`=255).
  - Both counters free-run in every state, including during `estop`.
- **PWM output.** `pwm_out` is registered: `pwm_out`(t+1) = (`duty`(t)=255) OR (`pwm_cnt`(t) < `duty`(t)).
  - Duty 0 gives constant low.
  - Duty 255 gives constant high.
- **Update timing.** `duty`, `state` and the ramp/hold-off counters change only on a `period_end` clock. The single exception is `estop`.
- **State transitions at `period_end`.**
  - **IDLE:** if `motor_on`=1, go to RAMP_UP. Duty stays 0 and the ramp counter clears.
  - **RAMP_UP:**
    - If `motor_on`=0, go to RAMP_DOWN. Clear the ramp counter; no step is taken on this boundary.
    - Otherwise the ramp counter increments. When it reaches `RAMP_PERIODS`, clear it and set duty = min(duty+`STEP`, 255), computed 9-bit and saturated.
    - The new duty equals 255 → go to RUN on that same boundary.
  - **RUN:** if `motor_on`=0, go to RAMP_DOWN with the ramp counter cleared.
  - **RAMP_DOWN:**
    - If `motor_on`=1, go to RAMP_UP, continuing from the current duty. Clear the ramp counter.
    - Otherwise step as in RAMP_UP, with duty = max(duty−`STEP`, 0) and no underflow.
    - The new duty equals 0 → go to HOLDOFF on that boundary, with the hold-off counter cleared.
  - **HOLDOFF:** `motor_on` is ignored. The hold-off counter increments each boundary. When it reaches `HOLDOFF_PERIODS`, go to IDLE. A still-high `motor_on` then starts RAMP_UP at the next boundary.
- **Emergency stop.** While `estop`=1 on any clock, regardless of `period_end`:
  - `duty` goes to 0, `state` to HOLDOFF, and the hold-off counter clears, all on the next edge.
  - Consequently `pwm_out`=0 from the following edge.
  - While `estop` is held, the hold-off counter stays cleared. Counting starts at the first `period_end` after release.
- **Output decode.** `running` and `holdoff` are decoded from registered state, with no extra latency.
- **Counter widths.** The ramp and hold-off counters are sized by `$clog2` of their parameter, with a minimum of 1 bit.

## Timing
- **Reset values:** `presc`=0, `pwm_cnt`=0, `duty`=0, `state`=IDLE, `pwm_out`=0, `running`=0, `holdoff`=0, all internal counters 0.
  - Reset asserted mid-ramp, mid-run or in HOLDOFF forces the reset values immediately (asynchronously).
  - After reset release, there is no hold-off.
- **Request latency:** from `motor_on` rising to first duty change = time to next `period_end` + `RAMP_PERIODS` periods.
- **Stop latency:** from `motor_on` falling to first decrement = time to next `period_end` + `RAMP_PERIODS` periods.
- **Full ramp:** ⌈255/`STEP`⌉×`RAMP_PERIODS` periods after RAMP_UP entry.
- **Duty change on `pwm_out`:** a duty change on a `period_end` edge first appears during the period starting at `pwm_cnt`=0, delayed by one clock because of the output register.
- **Simultaneous events:**
  - `estop` beats `period_end` and `motor_on`.
  - A direction change beats a step on the same boundary.
  - `motor_on` toggling between boundaries is invisible; only its value at `period_end` matters.
- **Glitches:** `pwm_out` has no glitches and no partial-period duty change.

## Test plan
Parameters for all scenarios unless stated: `PRESC`=1, `RAMP_PERIODS`=1, `STEP`=64, `HOLDOFF_PERIODS`=2. A PWM period is 256 clocks.
1. **Reset.** Assert `reset` mid-count with `motor_on`=1 → all outputs 0 and state 0 on the same clock. After release, state IDLE.
2. **Soft start.** Raise `motor_on` → successive `period_end` edges give state 1, then duty 64, 128, 192, 255. `running`=1 with the 255 step. `pwm_out` is high for exactly 64/128/192 clocks per period, then constant high.
3. **Soft stop and hold-off.** From RUN, drop `motor_on` → duty 191, 127, 63, 0, with HOLDOFF entered at 0. Re-raising `motor_on` during HOLDOFF is ignored. IDLE follows 2 boundaries later, then RAMP_UP on the next boundary.
4. **Reversal.** Drop `motor_on` at duty 128 in RAMP_UP → state 3 at the next boundary with duty held at 128, then 64. Raise `motor_on` → state 1 with duty held, then 128.
5. **Emergency stop.** Pulse `estop` for 1 clock mid-period in RUN → `duty`=0 and `holdoff`=1 on the next edge, `pwm_out`=0 on the following edge. IDLE is reached after 2 further `period_end` edges.
6. **Saturation.** With `STEP`=255 and `RAMP_PERIODS`=3 → duty goes 0→255 after 3 periods and 255→0 after 3 periods. No wrap occurs.
